keypad_entry_display: RTL
=========================

Name: keypad_entry_display

Overview:
Parametrised successor to the single-digit keypad-to-display path. It scans a 4x4 matrix keypad and debounces presses at full-scan granularity, rejecting multi-key ghosts. Accepted hex digits shift into an NUM_DIGITS-wide entry register, which drives a time-multiplexed NUM_DIGITS seven-segment display with leading-digit blanking. It sits between the Pmod keypad header and the board display pins, and also exports the entry value and key strobe to downstream logic.

Parameters:
SCAN_DIV, 100000, clk cycles each column is held driven (1 ms at 100 MHz); must be >= 2
DB_SCANS, 4, consecutive identical full scans required to accept a press or release; must be >= 1
NUM_DIGITS, 4, entry/display digit count; 1..8
REFRESH_DIV, 100000, clk cycles each display digit is lit; must be >= 1

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
row  input  4  keypad rows, active-low (pulled up); row[0] is top row
col  output  4  keypad column drive, one-hot low; col[0] is leftmost column
clear  input  1  synchronous pulse; empties the entry register
key_valid  output  1  one-cycle strobe when a press is accepted
key_code  output  4  code of the last accepted key, held until the next press
entry  output  4*NUM_DIGITS  entered value; nibble 0 holds the most recent key
an  output  NUM_DIGITS  digit anodes, active-low; an[0] is rightmost
seg  output  7  cathodes, active-low, seg[0]=a .. seg[6]=g

Behaviour:
- Reset (async assert, sync release): col=4'b1110, key_valid=0, key_code=0, entry=0, digit count=0, an all 1s, seg=7'h7F, column index=0, refresh index=0, debounce FSM=IDLE.
- Scan: column index c drives col=~(1<<c) for SCAN_DIV cycles. ~row is sampled on the final cycle of the hold; c then advances 0→1→2→3→0. A full scan ends at the c=3 sample.
- Key map (row r, col c): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
- Scan result: exactly one asserted (row,col) across the 4 samples gives SINGLE(code). Zero asserted gives NONE. Two or more asserted gives NONE (ghost rejection).
- Debounce FSM, evaluated once per completed scan:
  - IDLE: on SINGLE(k), go to CAND with cand=k and cnt=1. If DB_SCANS=1, accept immediately instead.
  - CAND: SINGLE(cand) increments cnt; when cnt reaches DB_SCANS, accept and go to HELD. SINGLE(other) restarts CAND with the new code and cnt=1. NONE returns to IDLE.
  - HELD: NONE increments rcnt; at DB_SCANS go to IDLE. Any SINGLE resets rcnt=0; a different key while HELD is ignored. No auto-repeat.
- Accept: on the cycle after the scan-end sample, key_valid=1 for exactly one cycle and key_code=k. In the same cycle, entry is shifted left 4 with entry[3:0]=k (the top nibble is lost), and count increments, saturating at NUM_DIGITS.
- Clear: entry=0 and count=0 on the next cycle. Clear coinciding with an accept: clear wins, key_valid is suppressed, key_code is unchanged, and the FSM still goes to HELD.
- Display: refresh index d advances every REFRESH_DIV cycles and wraps from NUM_DIGITS-1 to 0.
  - If d<count: an=~(1<<d) and seg=hex(entry nibble d).
  - Otherwise: an all 1s and seg=7'h7F (blank).
  - A count of 0 gives a fully dark display.
- seg hex values (active-low, 0..F): 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- Outputs are registered. Scan and refresh counters run freely and independently, including while a key is held. Reset mid-scan or mid-debounce discards all state, and no key_valid is emitted.

Test Plan:
- Bench parameters: SCAN_DIV=4, DB_SCANS=3, NUM_DIGITS=4, REFRESH_DIV=8.
- Reset release, no keys → col cycles 1110,1101,1011,0111 every 4 clks; an=1111 and seg=7F throughout; key_valid never asserts.
- Hold row0 low while col=1101 (key 2) for 3 full scans → single key_valid pulse with key_code=2, 1 clk after the 3rd scan end; entry=0x0002; an[0] lit with seg=24.
- Press 1, release, then 2, 3, 4, 5 (each debounced) → entry=0x2345, count=4; an cycles 1110,1101,1011,0111 showing 5,4,3,2.
- Bounce: key 7 present for 2 scans, absent for 1, present for 3 → exactly one key_valid with code 7. Holding 7 for 20 scans gives no further pulses.
- Two keys (row0/col0 and row1/col1) held together for 10 scans → no key_valid; entry unchanged.
- clear asserted in the same cycle as an accept of key A → key_valid stays 0, entry=0, display dark. A later key B after release gives entry=0x000B.

Source files
------------

// File: rtl/keypad_entry_display_if.sv
// Keypad/display pin bundle for keypad_entry_display: keypad matrix, clear
// input, key strobe/code, entry value and multiplexed seven-segment outputs.
interface keypad_entry_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]              row;
    logic [3:0]              col;
    logic                    clear;
    logic                    key_valid;
    logic [3:0]              key_code;
    logic [4*NUM_DIGITS-1:0] entry;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;

    modport slave (
        input  row, clear,
        output col, key_valid, key_code, entry, an, seg
    );

    modport master (
        output row, clear,
        input  col, key_valid, key_code, entry, an, seg
    );
endinterface

// File: rtl/keypad_entry_display.sv
// 4x4 keypad scanner with full-scan debounce and ghost rejection, feeding a
// shifting hex entry register shown on a multiplexed NUM_DIGITS 7-seg display.
module keypad_entry_display #(
    parameter int SCAN_DIV    = 100000,
    parameter int DB_SCANS    = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_entry_display_if.slave bus
);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RFW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DGW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNW = $clog2(NUM_DIGITS + 1);
    localparam int DBW = $clog2(DB_SCANS + 1);
    localparam int EW  = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, CAND, HELD} db_state_e;

    function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_at = 4'h1;  4'h1: key_at = 4'h2;  4'h2: key_at = 4'h3;  4'h3: key_at = 4'hA;
            4'h4: key_at = 4'h4;  4'h5: key_at = 4'h5;  4'h6: key_at = 4'h6;  4'h7: key_at = 4'hB;
            4'h8: key_at = 4'h7;  4'h9: key_at = 4'h8;  4'hA: key_at = 4'h9;  4'hB: key_at = 4'hC;
            4'hC: key_at = 4'h0;  4'hD: key_at = 4'hF;  4'hE: key_at = 4'hE;  default: key_at = 4'hD;
        endcase
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // ---------------- column scan ----------------
    logic [SCW-1:0] scan_cnt_q;
    logic [1:0]     col_idx_q;
    logic [3:0]     col_q;
    logic           sample;

    assign sample = (scan_cnt_q == SCW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            col_idx_q  <= '0;
            col_q      <= 4'b1110;
        end else if (sample) begin
            scan_cnt_q <= '0;
            col_idx_q  <= col_idx_q + 2'd1;
            col_q      <= ~(4'b0001 << (col_idx_q + 2'd1));
        end else begin
            scan_cnt_q <= scan_cnt_q + SCW'(1);
        end
    end

    // Hit count saturates at 2: anything above one key is a ghost/NONE.
    logic [1:0] col_hits, base_n, acc_n_q, scan_n;
    logic [3:0] col_code, base_code, acc_code_q, scan_code;
    logic [2:0] tot_n;
    logic       scan_end, single;

    always_comb begin
        col_hits = '0;
        col_code = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!bus.row[r]) begin
                col_code = key_at(2'(r), col_idx_q);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
        base_n    = (col_idx_q == 2'd0) ? 2'd0 : acc_n_q;
        base_code = (col_idx_q == 2'd0) ? 4'd0 : acc_code_q;
        tot_n     = {1'b0, base_n} + {1'b0, col_hits};
        scan_n    = (tot_n >= 3'd2) ? 2'd2 : tot_n[1:0];
        scan_code = (col_hits != 2'd0) ? col_code : base_code;
    end

    assign scan_end = sample && (col_idx_q == 2'd3);
    assign single   = (scan_n == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_n_q    <= '0;
            acc_code_q <= '0;
        end else if (sample) begin
            acc_n_q    <= scan_n;
            acc_code_q <= scan_code;
        end
    end

    // ---------------- debounce FSM ----------------
    db_state_e      state_q, state_d;
    logic [3:0]     cand_q, cand_d;
    logic [DBW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic           accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        accept  = 1'b0;
        if (scan_end) begin
            case (state_q)
                IDLE: if (single) begin
                    if (DB_SCANS == 1) begin
                        accept  = 1'b1;
                        state_d = HELD;
                        rcnt_d  = '0;
                    end else begin
                        state_d = CAND;
                        cand_d  = scan_code;
                        cnt_d   = DBW'(1);
                    end
                end
                CAND: begin
                    if (!single) begin
                        state_d = IDLE;
                    end else if (scan_code != cand_q) begin
                        cand_d = scan_code;
                        cnt_d  = DBW'(1);
                    end else if (cnt_q + DBW'(1) == DBW'(DB_SCANS)) begin
                        accept  = 1'b1;
                        state_d = HELD;
                        rcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + DBW'(1);
                    end
                end
                HELD: begin
                    if (single) begin
                        rcnt_d = '0;
                    end else if (rcnt_q + DBW'(1) == DBW'(DB_SCANS)) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + DBW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- entry register ----------------
    logic           key_valid_q;
    logic [3:0]     key_code_q;
    logic [EW-1:0]  entry_q;
    logic [CNW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            entry_q     <= '0;
            count_q     <= '0;
        end else begin
            key_valid_q <= accept && !bus.clear;
            if (bus.clear) begin
                entry_q <= '0;
                count_q <= '0;
            end else if (accept) begin
                key_code_q <= scan_code;
                entry_q    <= (entry_q << 4) | EW'(scan_code);
                if (count_q != CNW'(NUM_DIGITS)) count_q <= count_q + CNW'(1);
            end
        end
    end

    // ---------------- display refresh ----------------
    logic [RFW-1:0]        ref_cnt_q;
    logic [DGW-1:0]        dig_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            dig_q     <= '0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
        end else begin
            if (ref_cnt_q == RFW'(REFRESH_DIV - 1)) begin
                ref_cnt_q <= '0;
                dig_q     <= (dig_q == DGW'(NUM_DIGITS - 1)) ? '0 : dig_q + DGW'(1);
            end else begin
                ref_cnt_q <= ref_cnt_q + RFW'(1);
            end
            if (int'(dig_q) < int'(count_q)) begin
                an_q  <= ~(NUM_DIGITS'(1) << dig_q);
                seg_q <= hex7(entry_q[{dig_q, 2'b00} +: 4]);
            end else begin
                an_q  <= '1;
                seg_q <= 7'h7F;
            end
        end
    end

    assign bus.col       = col_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.entry     = entry_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
endmodule
